// File: rtl/fp_align_add.sv
// Two-stage align-and-add front end for the binary32 adder/subtractor:
// orders operands by magnitude, aligns the smaller one, and forms the raw 25-bit magnitude sum.
module fp_align_add (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        op_sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [24:0] significand,
  output logic [7:0]  exponent_a,
  output logic        sign,
  output logic        special
);

  logic        w_adv;
  logic [7:0]  w_a_exp, w_b_exp;
  logic [23:0] w_a_mant, w_b_mant;
  logic        w_b_sign;
  logic        w_a_is_l;
  logic [7:0]  w_l_exp, w_s_exp;
  logic [23:0] w_l_mant, w_s_mant;
  logic        w_l_sign;
  logic        w_special;

  logic        r1_valid;
  logic [7:0]  r1_lexp;
  logic [23:0] r1_lmant;
  logic [23:0] r1_smant;
  logic [7:0]  r1_diff;
  logic        r1_lsign;
  logic        r1_effsub;
  logic        r1_special;

  logic [23:0] w_aligned;
  logic [24:0] w_sum;
  logic        w_sign;

  logic        r_out_valid;
  logic [24:0] r_significand;
  logic [7:0]  r_exponent;
  logic        r_sign;
  logic        r_special;

  assign w_adv    = !r_out_valid | out_ready;
  assign in_ready = w_adv;

  // Denormals flush to zero: exponent 0 means no hidden bit and no fraction.
  assign w_a_exp   = a[30:23];
  assign w_b_exp   = b[30:23];
  assign w_a_mant  = (w_a_exp == 8'd0) ? '0 : {1'b1, a[22:0]};
  assign w_b_mant  = (w_b_exp == 8'd0) ? '0 : {1'b1, b[22:0]};
  assign w_b_sign  = b[31] ^ op_sub;
  assign w_a_is_l  = {w_a_exp, w_a_mant} >= {w_b_exp, w_b_mant};
  assign w_special = (w_a_exp == 8'hFF) | (w_b_exp == 8'hFF);

  always_comb begin
    w_l_exp  = w_a_exp;
    w_s_exp  = w_b_exp;
    w_l_mant = w_a_mant;
    w_s_mant = w_b_mant;
    w_l_sign = a[31];
    if (!w_a_is_l) begin
      w_l_exp  = w_b_exp;
      w_s_exp  = w_a_exp;
      w_l_mant = w_b_mant;
      w_s_mant = w_a_mant;
      w_l_sign = w_b_sign;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_valid   <= 1'b0;
      r1_lexp    <= '0;
      r1_lmant   <= '0;
      r1_smant   <= '0;
      r1_diff    <= '0;
      r1_lsign   <= 1'b0;
      r1_effsub  <= 1'b0;
      r1_special <= 1'b0;
    end else if (w_adv) begin
      r1_valid   <= in_valid;
      r1_lexp    <= w_l_exp;
      r1_lmant   <= w_l_mant;
      r1_smant   <= w_s_mant;
      r1_diff    <= w_l_exp - w_s_exp;
      r1_lsign   <= w_l_sign;
      r1_effsub  <= a[31] ^ w_b_sign;
      r1_special <= w_special;
    end
  end

  // Shifted-out bits are truncated; the ordering guarantees a non-negative difference.
  assign w_aligned = (r1_diff >= 8'd24) ? '0 : (r1_smant >> r1_diff);

  always_comb begin
    w_sum  = r1_effsub ? ({1'b0, r1_lmant} - {1'b0, w_aligned})
                       : ({1'b0, r1_lmant} + {1'b0, w_aligned});
    w_sign = (w_sum == 25'd0) ? 1'b0 : r1_lsign;
    if (r1_special) begin
      w_sum  = '0;
      w_sign = r1_lsign;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid   <= 1'b0;
      r_significand <= '0;
      r_exponent    <= '0;
      r_sign        <= 1'b0;
      r_special     <= 1'b0;
    end else if (w_adv) begin
      r_out_valid   <= r1_valid;
      r_significand <= w_sum;
      r_exponent    <= r1_lexp;
      r_sign        <= w_sign;
      r_special     <= r1_special;
    end
  end

  assign out_valid   = r_out_valid;
  assign significand = r_significand;
  assign exponent_a  = r_exponent;
  assign sign        = r_sign;
  assign special     = r_special;

endmodule

// File: tb/tb_fp_align_add.sv
// Scoreboard bench for fp_align_add: a value-level model predicts each result at acceptance,
// and a monitor thread checks results in order as the DUT hands them off.
module tb_fp_align_add;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        op_sub;
  logic        out_valid;
  logic        out_ready;
  logic [24:0] significand;
  logic [7:0]  exponent_a;
  logic        sign;
  logic        special;

  fp_align_add dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op_sub(op_sub), .out_valid(out_valid), .out_ready(out_ready),
    .significand(significand), .exponent_a(exponent_a), .sign(sign), .special(special)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks;
  int          n_pass;
  int          n_acc;
  int          n_out;
  int          n_drop;
  logic        rnd_ready;
  logic [34:0] exp_q[$];
  logic [34:0] prev_vals;
  logic        prev_stall;

  // Value-level reference: magnitudes as integers, alignment as integer division.
  function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic s);
    longint ea, eb, ma, mb, el, es, ml, ms, al, r;
    logic   sa, sbe, sl, sp, sg;
    ea  = longint'(x[30:23]);
    eb  = longint'(y[30:23]);
    ma  = (ea == 0) ? 0 : longint'(x[22:0]) + 8388608;
    mb  = (eb == 0) ? 0 : longint'(y[22:0]) + 8388608;
    sa  = x[31];
    sbe = y[31] ^ s;
    if (ea * 16777216 + ma >= eb * 16777216 + mb) begin
      el = ea; ml = ma; sl = sa; es = eb; ms = mb;
    end else begin
      el = eb; ml = mb; sl = sbe; es = ea; ms = ma;
    end
    al = (el - es >= 24) ? 0 : ms / (longint'(1) << (el - es));
    r  = (sa != sbe) ? ml - al : ml + al;
    sp = (ea == 255) || (eb == 255);
    sg = sl;
    if (sp) r = 0;
    else if (r == 0) sg = 1'b0;
    return {r[24:0], el[7:0], sg, sp};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: actual %h required %h", nm, act, want);
  endtask

  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic ok;
    int   guard;
    a = x; b = y; op_sub = s; in_valid = 1'b1;
    ok = 1'b0;
    guard = 0;
    do begin
      if (rnd_ready) out_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
      guard++;
    end while (!ok && guard < 200);
    if (!ok) begin
      n_checks++;
      $display("FAIL send_timeout: in_ready never rose for a=%h b=%h", x, y);
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      if (rnd_ready) out_ready = ($urandom_range(3) != 0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [31:0] x, y;
    int          guard;
    n_checks = 0; n_pass = 0; n_acc = 0; n_out = 0; n_drop = 0;
    prev_stall = 1'b0; prev_vals = '0;
    rnd_ready = 1'b0;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op_sub = 1'b0; out_ready = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (!rst && in_valid && in_ready) begin
          exp_q.push_back(model(a, b, op_sub));
          n_acc++;
        end
      end
      forever begin
        @(negedge clk);
        if (rst || !out_valid) begin
          prev_stall = 1'b0;
        end else begin
          if (prev_stall)
            check("hold_stable", 64'({significand, exponent_a, sign, special}), 64'(prev_vals));
          prev_vals  = {significand, exponent_a, sign, special};
          prev_stall = !out_ready;
          if (out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
              n_checks++;
              $display("FAIL extra_output: got %h with no pending expectation", prev_vals);
            end else begin
              check("result", 64'(prev_vals), 64'(exp_q.pop_front()));
            end
          end
        end
      end
      begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    #3;
    check("reset_outputs", 64'({out_valid, significand, exponent_a, sign, special}), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    send(32'h3F800000, 32'h3F800000, 1'b0);
    send(32'h40000000, 32'h40400000, 1'b1);
    send(32'h3F800000, 32'h3F800000, 1'b1);
    send(32'h3F800000, 32'h30800000, 1'b0);
    send(32'h3F800000, 32'h34000000, 1'b0);
    send(32'h3F800000, 32'h33800000, 1'b1);
    send(32'h7F800000, 32'h3F800000, 1'b0);
    send(32'h00000000, 32'hBF800000, 1'b0);
    send(32'h00000000, 32'h00000000, 1'b1);
    idle(4);

    out_ready = 1'b0;
    send(32'h3FC00000, 32'h3F000000, 1'b0);
    send(32'h41200000, 32'h40A00000, 1'b1);
    check("stall_in_ready", 64'(in_ready), 64'd0);
    idle(3);
    out_ready = 1'b1;
    send(32'hC0400000, 32'h3E800000, 1'b0);
    send(32'h42C80000, 32'h42C80000, 1'b0);
    idle(4);

    rnd_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      x = $urandom;
      y = $urandom;
      case ($urandom_range(7))
        0: y[30:23] = x[30:23];
        1: y = x;
        2: x[30:23] = 8'd0;
        3: y[30:23] = 8'hFF;
        4, 5: y[30:23] = x[30:23] - 8'($urandom_range(30));
        default: ;
      endcase
      send(x, y, 1'($urandom_range(1)));
      if ($urandom_range(7) == 0) idle(1);
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    idle(4);

    out_ready = 1'b0;
    send(32'h3F800000, 32'h40000000, 1'b0);
    send(32'h40800000, 32'h3F800000, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async_reset_out_valid", 64'(out_valid), 64'd0);
    check("async_reset_in_ready", 64'(in_ready), 64'd1);
    n_drop += exp_q.size();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    check("post_reset_in_ready", 64'(in_ready), 64'd1);
    send(32'h40400000, 32'h3F800000, 1'b0);
    @(negedge clk);
    check("latency_not_early", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("latency_two_cycles", 64'(out_valid), 64'd1);
    idle(2);

    guard = 0;
    while (exp_q.size() > 0 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    check("result_count", 64'(n_out), 64'(n_acc - n_drop));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
